vec_decode_stage: RTL and testbench
===================================

VEC_DECODE_STAGE -- requirements
Module: vec_decode_stage

Interface
REQ-001 SHALL have parameter N, default 16, meaning element width in bits.
REQ-002 SHALL have parameter LANES, default 16, meaning elements per vector register.
REQ-003 SHALL have parameter NREGS, default 16, meaning vector register count; AW = clog2(NREGS), and AW SHALL be at least 4.
REQ-004 Ports, in order: clk in 1, rising-edge clock; RST in 1, asynchronous active-low reset.
REQ-005 InstrD in 32, instruction; ValidD in 1, instruction present; RegWriteD in 1; ImmSrcD in 1, 1=sign-extend and 0=zero-extend; RegSrcD in 2, operand select.
REQ-006 RegWriteW in 1; WrMaskW in LANES, per-lane write enable; WA3W in AW, write address; WD3W in LANES x N, write data.
REQ-007 StallE in 1, downstream hold; FlushE in 1, squash instruction entering E.
REQ-008 RD1E, RD2E, ExtImmE out LANES x N; RA1E, RA2E, WA3E out AW; RegWriteE, ValidE out 1; HazardD out 1, holds fetch/decode.

Function
REQ-009 ra1 SHALL be all-ones (NREGS-1) when RegSrcD[0]=1, else InstrD[3:0].
REQ-010 ra2 SHALL be InstrD[7:4] when RegSrcD[1]=1, else InstrD[11:8].
REQ-011 Destination wa3D SHALL be InstrD[11:8].
REQ-012 16-bit immediate SHALL be {InstrD[1:0], InstrD[31:18]}, zero- or sign-extended to N per ImmSrcD, and replicated into every lane.
REQ-013 Register file write SHALL occur on the rising clk when RegWriteW=1; only lanes with WrMaskW[i]=1 are updated.
REQ-014 Reads SHALL be combinational with write-through bypass: a read matching WA3W while RegWriteW=1 returns WD3W in masked lanes and stored data in unmasked lanes.
REQ-015 Scoreboard: one pending bit per register.
REQ-016 hazard = ValidD & (pending[ra1] & !(RegWriteW & WA3W==ra1) | pending[ra2] & !(RegWriteW & WA3W==ra2)).
REQ-017 Write-back to a pending register SHALL resolve the hazard in the same cycle via bypass; no stall.
REQ-018 HazardD SHALL equal hazard | StallE.
REQ-019 Issue = ValidD & !hazard & !StallE & !FlushE.
REQ-020 On issue, the E register SHALL load all D outputs with ValidE=1, and pending[wa3D] SHALL be set if RegWriteD=1.
REQ-021 FlushE=1 SHALL load a bubble (ValidE=0, RegWriteE=0, data don't-care) regardless of StallE; flush dominates stall.
REQ-022 StallE=1 with FlushE=0 SHALL hold every E output unchanged.
REQ-023 hazard=1 with StallE=0 and FlushE=0 SHALL load a bubble; the D instruction is retried next cycle.
REQ-024 RegWriteW=1 SHALL clear pending[WA3W], regardless of WrMaskW.
REQ-025 Simultaneous set and clear of the same pending bit: set wins.
REQ-026 Latency SHALL be 1 clock from D to E outputs; throughput is 1 instruction/cycle absent hazards.

Reset
REQ-027 RST=0 SHALL asynchronously clear all registers, all pending bits, and all E outputs to 0, including ValidE and RegWriteE.
REQ-028 After reset, HazardD SHALL be 0 unless StallE=1.
REQ-029 A write-back coincident with reset release SHALL be ignored when RST is low at that edge.

Structure
REQ-030 Shared package vec_pkg SHALL hold the lane-vector typedef, the instruction field bit positions, and the extend-mode enum.
REQ-031 Register storage SHALL be the sub-module vec_regfile: NREGS x LANES x N, two read ports, one masked write port, bypass included.
REQ-032 Scoreboard, field decode, extend, and the E register SHALL live in vec_decode_stage.

Verification
REQ-033 Reset, then RegWriteW=1, WA3W=3, WrMaskW=all-ones, WD3W lanes=0x00AA; next cycle issue with ra1=3 -> RD1E lanes=0x00AA, ValidE=1.
REQ-034 WrMaskW=0x0001, WD3W=0x1234 to register 5 holding 0x0 -> lane0=0x1234, lanes1..15=0x0000; same-cycle read returns the same values.
REQ-035 Issue a writer of r2 (RegWriteD=1), then immediately a reader of r2 -> HazardD=1 and bubble until WA3W=2 write-back; reader issues in the write-back cycle with bypassed data.
REQ-036 StallE=1 for 3 cycles -> E outputs constant and HazardD=1; FlushE=1 with StallE=1 -> ValidE=0 and pending unchanged.
REQ-037 ImmSrcD=1, InstrD[1:0]=2'b10, InstrD[31:18]=0 -> ExtImmE lanes=0x8000; ImmSrcD=0, InstrD[1:0]=2'b11, InstrD[31:18]=all-ones -> ExtImmE lanes=0xFFFF (N=16).
REQ-038 Assert RST=0 mid-stall with pending r7 set -> pending cleared, ValidE=0 immediately, and a subsequent r7 reader issues without a hazard.

Source files
------------

// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared types, instruction field positions and decode helpers for the vector decode stage
package vec_pkg;

  localparam int INSTR_W     = 32;
  localparam int FLD_W       = 4;
  localparam int RA1_LSB     = 0;
  localparam int RA2_ALT_LSB = 4;
  localparam int RA2_LSB     = 8;
  localparam int WA3_LSB     = 8;
  localparam int IMM_HI_LSB  = 0;
  localparam int IMM_HI_W    = 2;
  localparam int IMM_LO_LSB  = 18;
  localparam int IMM_LO_W    = 14;
  localparam int IMM_W       = IMM_HI_W + IMM_LO_W;

  localparam int DEF_N     = 16;
  localparam int DEF_LANES = 16;

  // Lane vector at the default geometry; lane i occupies bits [i*N +: N].
  typedef logic [DEF_LANES-1:0][DEF_N-1:0] lane_vec_t;

  typedef enum logic {
    EXT_ZERO = 1'b0,
    EXT_SIGN = 1'b1
  } ext_mode_e;

  function automatic logic [FLD_W-1:0] fld_ra1(input logic [INSTR_W-1:0] instr);
    return instr[RA1_LSB +: FLD_W];
  endfunction

  function automatic logic [FLD_W-1:0] fld_ra2(input logic [INSTR_W-1:0] instr, input logic alt);
    return alt ? instr[RA2_ALT_LSB +: FLD_W] : instr[RA2_LSB +: FLD_W];
  endfunction

  function automatic logic [FLD_W-1:0] fld_wa3(input logic [INSTR_W-1:0] instr);
    return instr[WA3_LSB +: FLD_W];
  endfunction

  // The two low instruction bits form the immediate's top bits (shared with the ra1 field).
  function automatic logic [IMM_W-1:0] fld_imm(input logic [INSTR_W-1:0] instr);
    return {instr[IMM_HI_LSB +: IMM_HI_W], instr[IMM_LO_LSB +: IMM_LO_W]};
  endfunction

endpackage

// File: rtl/vec_regfile.sv
// rtl/vec_regfile.sv - NREGS x LANES x N vector register file, two read ports, one lane-masked write port
module vec_regfile #(
  parameter int N     = 16,
  parameter int LANES = 16,
  parameter int NREGS = 16,
  parameter int AW    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [AW-1:0]        ra1,
  input  logic [AW-1:0]        ra2,
  output logic [LANES*N-1:0]   rd1,
  output logic [LANES*N-1:0]   rd2,
  input  logic                 we,
  input  logic [LANES-1:0]     wmask,
  input  logic [AW-1:0]        wa,
  input  logic [LANES*N-1:0]   wd
);

  logic [LANES*N-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) mem[r] <= '0;
    end else if (we) begin
      for (int l = 0; l < LANES; l++)
        if (wmask[l]) mem[wa][l*N +: N] <= wd[l*N +: N];
    end
  end

  // Write-through: a read of the register being written sees the new lanes this cycle.
  function automatic logic [LANES*N-1:0] read_port(input logic [AW-1:0] a);
    logic [LANES*N-1:0] v;
    v = mem[a];
    if (we && (wa == a))
      for (int l = 0; l < LANES; l++)
        if (wmask[l]) v[l*N +: N] = wd[l*N +: N];
    return v;
  endfunction

  always_comb begin
    rd1 = read_port(ra1);
    rd2 = read_port(ra2);
  end

endmodule

// File: rtl/vec_decode_stage.sv
// rtl/vec_decode_stage.sv - vector decode stage: field decode, scoreboard, immediate extend and E register
module vec_decode_stage
  import vec_pkg::*;
#(
  parameter int N     = 16,
  parameter int LANES = 16,
  parameter int NREGS = 16,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic [31:0]          InstrD,
  input  logic                 ValidD,
  input  logic                 RegWriteD,
  input  logic                 ImmSrcD,
  input  logic [1:0]           RegSrcD,
  input  logic                 RegWriteW,
  input  logic [LANES-1:0]     WrMaskW,
  input  logic [AW-1:0]        WA3W,
  input  logic [LANES*N-1:0]   WD3W,
  input  logic                 StallE,
  input  logic                 FlushE,
  output logic [LANES*N-1:0]   RD1E,
  output logic [LANES*N-1:0]   RD2E,
  output logic [LANES*N-1:0]   ExtImmE,
  output logic [AW-1:0]        RA1E,
  output logic [AW-1:0]        RA2E,
  output logic [AW-1:0]        WA3E,
  output logic                 RegWriteE,
  output logic                 ValidE,
  output logic                 HazardD
);

  logic [AW-1:0]      ra1, ra2, wa3d;
  logic [IMM_W-1:0]   imm16;
  logic [N-1:0]       ext_elem;
  logic [LANES*N-1:0] ext_imm, rd1, rd2;
  logic [NREGS-1:0]   pending, pending_next;
  logic               hazard, issue;
  ext_mode_e          ext_mode;

  assign ra1      = RegSrcD[0] ? AW'(NREGS-1) : AW'(fld_ra1(InstrD));
  assign ra2      = AW'(fld_ra2(InstrD, RegSrcD[1]));
  assign wa3d     = AW'(fld_wa3(InstrD));
  assign imm16    = fld_imm(InstrD);
  assign ext_mode = ext_mode_e'(ImmSrcD);
  assign ext_elem = (ext_mode == EXT_SIGN) ? N'($signed(imm16)) : N'(imm16);
  assign ext_imm  = {LANES{ext_elem}};

  vec_regfile #(
    .N     (N),
    .LANES (LANES),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_regfile (
    .clk   (clk),
    .rst_n (RST),
    .ra1   (ra1),
    .ra2   (ra2),
    .rd1   (rd1),
    .rd2   (rd2),
    .we    (RegWriteW),
    .wmask (WrMaskW),
    .wa    (WA3W),
    .wd    (WD3W)
  );

  // A pending source being written back this cycle is already covered by the bypass.
  assign hazard = ValidD & ((pending[ra1] & ~(RegWriteW & (WA3W == ra1))) |
                            (pending[ra2] & ~(RegWriteW & (WA3W == ra2))));
  assign HazardD = hazard | StallE;
  assign issue   = ValidD & ~hazard & ~StallE & ~FlushE;

  always_comb begin
    pending_next = pending;
    if (RegWriteW) pending_next[WA3W] = 1'b0;
    if (issue && RegWriteD) pending_next[wa3d] = 1'b1;
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) pending <= '0;
    else      pending <= pending_next;
  end

  // Flush overrides stall; issue already excludes flush and hazard, so it doubles as the valid bit.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      RD1E      <= '0;
      RD2E      <= '0;
      ExtImmE   <= '0;
      RA1E      <= '0;
      RA2E      <= '0;
      WA3E      <= '0;
      RegWriteE <= 1'b0;
      ValidE    <= 1'b0;
    end else if (FlushE || !StallE) begin
      RD1E      <= rd1;
      RD2E      <= rd2;
      ExtImmE   <= ext_imm;
      RA1E      <= ra1;
      RA2E      <= ra2;
      WA3E      <= wa3d;
      RegWriteE <= issue & RegWriteD;
      ValidE    <= issue;
    end
  end

endmodule

// File: tb/tb_vec_decode_stage.sv
// tb/tb_vec_decode_stage.sv - randomized and directed self-checking bench for vec_decode_stage
module tb_vec_decode_stage;
  import vec_pkg::*;

  logic         clk = 1'b0;
  logic         RST;
  logic [31:0]  InstrD;
  logic         ValidD, RegWriteD, ImmSrcD;
  logic [1:0]   RegSrcD;
  logic         RegWriteW;
  logic [15:0]  WrMaskW;
  logic [3:0]   WA3W;
  logic [255:0] WD3W;
  logic         StallE, FlushE;
  logic [255:0] RD1E, RD2E, ExtImmE;
  logic [3:0]   RA1E, RA2E, WA3E;
  logic         RegWriteE, ValidE, HazardD;

  vec_decode_stage #(.N(16), .LANES(16), .NREGS(16)) dut (
    .clk(clk), .RST(RST), .InstrD(InstrD), .ValidD(ValidD), .RegWriteD(RegWriteD),
    .ImmSrcD(ImmSrcD), .RegSrcD(RegSrcD), .RegWriteW(RegWriteW), .WrMaskW(WrMaskW),
    .WA3W(WA3W), .WD3W(WD3W), .StallE(StallE), .FlushE(FlushE), .RD1E(RD1E), .RD2E(RD2E),
    .ExtImmE(ExtImmE), .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E), .RegWriteE(RegWriteE),
    .ValidE(ValidE), .HazardD(HazardD)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic last_hz;

  lane_vec_t m_reg [16];
  bit        m_pend [16];
  logic      m_ev, m_rwe;
  lane_vec_t m_rd1, m_rd2, m_imm;
  logic [3:0] m_ra1, m_ra2, m_wa3;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 16; r++) begin
      m_reg[r] = '0;
      m_pend[r] = 1'b0;
    end
    m_ev = 1'b0; m_rwe = 1'b0;
    m_rd1 = '0; m_rd2 = '0; m_imm = '0;
    m_ra1 = '0; m_ra2 = '0; m_wa3 = '0;
  endtask

  task automatic idle();
    InstrD = '0; ValidD = 1'b0; RegWriteD = 1'b0; ImmSrcD = 1'b0; RegSrcD = 2'b00;
    RegWriteW = 1'b0; WrMaskW = '0; WA3W = '0; WD3W = '0; StallE = 1'b0; FlushE = 1'b0;
  endtask

  function automatic logic [31:0] mk(input logic [3:0] f0, input logic [3:0] f4, input logic [3:0] f8);
    return {20'h0, f8, f4, f0};
  endfunction

  task automatic check_e();
    chk("valid_e", 256'(ValidE), 256'(m_ev));
    chk("regwrite_e", 256'(RegWriteE), 256'(m_rwe));
    if (m_ev) begin
      chk("rd1_e", RD1E, m_rd1);
      chk("rd2_e", RD2E, m_rd2);
      chk("extimm_e", ExtImmE, m_imm);
      chk("ra1_e", 256'(RA1E), 256'(m_ra1));
      chk("ra2_e", 256'(RA2E), 256'(m_ra2));
      chk("wa3_e", 256'(WA3E), 256'(m_wa3));
    end
  endtask

  // Entered just after a falling edge with inputs driven; leaves at the next falling edge.
  task automatic cycle();
    logic [3:0] a1, a2;
    logic [15:0] imm;
    logic hz, iss;
    lane_vec_t after [16];
    #1;
    a1 = RegSrcD[0] ? 4'd15 : InstrD[3:0];
    a2 = RegSrcD[1] ? InstrD[7:4] : InstrD[11:8];
    imm = {InstrD[1:0], InstrD[31:18]};
    hz = ValidD && ((m_pend[a1] && !(RegWriteW && WA3W == a1)) ||
                    (m_pend[a2] && !(RegWriteW && WA3W == a2)));
    last_hz = HazardD;
    chk("hazard_d", 256'(HazardD), 256'(hz || StallE));
    iss = ValidD && !hz && !StallE && !FlushE;
    for (int r = 0; r < 16; r++) after[r] = m_reg[r];
    if (RegWriteW)
      for (int l = 0; l < 16; l++)
        if (WrMaskW[l]) after[WA3W][l] = WD3W[l*16 +: 16];
    @(posedge clk);
    if (FlushE) begin
      m_ev = 1'b0; m_rwe = 1'b0;
    end else if (!StallE) begin
      m_ev = iss; m_rwe = iss && RegWriteD;
      if (iss) begin
        m_rd1 = after[a1]; m_rd2 = after[a2];
        m_imm = {16{imm}};
        m_ra1 = a1; m_ra2 = a2; m_wa3 = InstrD[11:8];
      end
    end
    for (int r = 0; r < 16; r++) m_reg[r] = after[r];
    if (RegWriteW) m_pend[WA3W] = 1'b0;
    if (iss && RegWriteD) m_pend[InstrD[11:8]] = 1'b1;
    #1;
    check_e();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    RST = 1'b0;
    idle();
    model_reset();
    @(negedge clk);
    RST = 1'b1;
  endtask

  initial begin
    RST = 1'b0;
    idle();
    model_reset();
    #12;
    chk("reset valid_e", 256'(ValidE), 256'd0);
    chk("reset regwrite_e", 256'(RegWriteE), 256'd0);
    chk("reset rd1_e", RD1E, 256'd0);
    chk("reset extimm_e", ExtImmE, 256'd0);
    chk("reset hazard", 256'(HazardD), 256'd0);
    StallE = 1'b1;
    #1;
    chk("reset hazard stall", 256'(HazardD), 256'd1);
    StallE = 1'b0;
    @(negedge clk);
    RST = 1'b1;

    // Immediate extension
    ValidD = 1'b1; RegSrcD = 2'b01; ImmSrcD = 1'b1;
    InstrD = {14'h0000, 16'h0, 2'b10};
    cycle();
    chk("imm sign 8000", ExtImmE, {16{16'h8000}});
    ImmSrcD = 1'b0;
    InstrD = {14'h3FFF, 16'h0, 2'b11};
    cycle();
    chk("imm zero ffff", ExtImmE, {16{16'hFFFF}});

    // Write r3 then read it
    idle();
    RegWriteW = 1'b1; WA3W = 4'd3; WrMaskW = 16'hFFFF; WD3W = {16{16'h00AA}};
    cycle();
    idle();
    ValidD = 1'b1; InstrD = mk(4'd3, 4'd0, 4'd0);
    cycle();
    chk("r3 read", RD1E, {16{16'h00AA}});
    chk("r3 valid", 256'(ValidE), 256'd1);

    // Masked write with same-cycle read
    idle();
    ValidD = 1'b1; InstrD = mk(4'd5, 4'd0, 4'd0);
    RegWriteW = 1'b1; WA3W = 4'd5; WrMaskW = 16'h0001; WD3W = {16{16'h1234}};
    cycle();
    chk("mask bypass", RD1E, {240'h0, 16'h1234});
    RegWriteW = 1'b0;
    cycle();
    chk("mask stored", RD1E, {240'h0, 16'h1234});

    // RAW hazard on r2 resolved by write-back bypass
    idle();
    ValidD = 1'b1; RegWriteD = 1'b1; InstrD = mk(4'd0, 4'd0, 4'd2);
    cycle();
    chk("writer issued", 256'(RegWriteE), 256'd1);
    RegWriteD = 1'b0; InstrD = mk(4'd2, 4'd0, 4'd0);
    cycle();
    chk("raw hazard", 256'(last_hz), 256'd1);
    chk("raw bubble", 256'(ValidE), 256'd0);
    cycle();
    chk("raw hazard again", 256'(last_hz), 256'd1);
    RegWriteW = 1'b1; WA3W = 4'd2; WrMaskW = 16'hFFFF; WD3W = {16{16'h5A5A}};
    cycle();
    chk("wb no hazard", 256'(last_hz), 256'd0);
    chk("wb issue", 256'(ValidE), 256'd1);
    chk("wb bypass data", RD1E, {16{16'h5A5A}});

    // Stall hold, then flush during stall
    idle();
    ValidD = 1'b1; InstrD = mk(4'd3, 4'd0, 4'd0);
    cycle();
    StallE = 1'b1; InstrD = mk(4'd5, 4'd0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall hazard_d", 256'(last_hz), 256'd1);
      chk("stall hold rd1", RD1E, {16{16'h00AA}});
      chk("stall hold valid", 256'(ValidE), 256'd1);
    end
    FlushE = 1'b1; RegWriteD = 1'b1; InstrD = mk(4'd0, 4'd0, 4'd9);
    cycle();
    chk("flush valid", 256'(ValidE), 256'd0);
    chk("flush regwrite", 256'(RegWriteE), 256'd0);
    idle();
    ValidD = 1'b1; InstrD = mk(4'd9, 4'd0, 4'd0);
    cycle();
    chk("flush no pending", 256'(last_hz), 256'd0);

    // Reset mid-stall with r7 pending; coincident write-back is dropped
    idle();
    ValidD = 1'b1; RegWriteD = 1'b1; InstrD = mk(4'd0, 4'd0, 4'd7);
    cycle();
    RegWriteD = 1'b0; StallE = 1'b1;
    cycle();
    #2;
    RST = 1'b0;
    RegWriteW = 1'b1; WA3W = 4'd4; WrMaskW = 16'hFFFF; WD3W = {256{1'b1}};
    #1;
    chk("async reset valid", 256'(ValidE), 256'd0);
    chk("async reset rd1", RD1E, 256'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    RST = 1'b1;
    idle();
    ValidD = 1'b1; InstrD = mk(4'd7, 4'd0, 4'd4);
    cycle();
    chk("r7 cleared", 256'(last_hz), 256'd0);
    chk("r7 issue", 256'(ValidE), 256'd1);
    chk("r4 write dropped", RD2E, 256'd0);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      InstrD    = $urandom();
      ValidD    = ($urandom_range(0, 9) < 8);
      RegWriteD = $urandom_range(0, 1);
      ImmSrcD   = $urandom_range(0, 1);
      RegSrcD   = 2'($urandom_range(0, 3));
      RegWriteW = ($urandom_range(0, 9) < 4);
      WrMaskW   = 16'($urandom());
      WA3W      = 4'($urandom_range(0, 15));
      for (int i = 0; i < 8; i++) WD3W[i*32 +: 32] = $urandom();
      StallE    = ($urandom_range(0, 9) < 2);
      FlushE    = ($urandom_range(0, 9) < 1);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
